// File: rtl/id_pipe.sv
// Hack instruction-decode stage: a small input queue with bypass feeding a
// registered decoder output, ready/valid on both sides, flush and an error counter.
module id_pipe #(
    parameter int PC_W   = 15,
    parameter int DEPTH  = 2,
    parameter int ECNT_W = 8,
    parameter int STRICT = 1
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       in_vld,
    output logic                       in_rdy,
    input  logic [15:0]                in_inst,
    input  logic [PC_W-1:0]            in_pc,
    input  logic                       flush,
    output logic                       out_vld,
    input  logic                       out_rdy,
    output logic [PC_W-1:0]            out_pc,
    output logic [5:0]                 out_alu,
    output logic [1:0]                 out_xsrc,
    output logic [1:0]                 out_ysrc,
    output logic [14:0]                out_imm,
    output logic [2:0]                 out_dst,
    output logic [2:0]                 out_jcond,
    output logic                       out_err,
    output logic [$clog2(DEPTH+1)-1:0] occ,
    output logic [ECNT_W-1:0]          err_cnt
);

    localparam int OCC_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [OCC_W-1:0] DEPTH_OCC = OCC_W'(DEPTH);

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [15:0]     inst;
    } raw_t;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [5:0]      alu;
        logic [1:0]      xsrc;
        logic [1:0]      ysrc;
        logic [14:0]     imm;
        logic [2:0]      dst;
        logic [2:0]      jcond;
        logic            err;
    } dec_t;

    function automatic dec_t decode(input raw_t r);
        dec_t d;
        d    = '0;
        d.pc = r.pc;
        if (!r.inst[15]) begin
            d.xsrc = 2'b10;
            d.imm  = r.inst[14:0];
            d.alu  = 6'b001100;
            d.dst  = 3'b100;
        end else begin
            d.alu   = r.inst[11:6];
            d.dst   = r.inst[5:3];
            d.jcond = r.inst[2:0];
            // inst[12] selects M instead of A; only some comp codes accept it
            case (r.inst[11:6])
                6'b001100, 6'b001101, 6'b001110, 6'b001111, 6'b011111: begin
                    d.xsrc = 2'b01;
                    d.err  = r.inst[12];
                end
                6'b101010, 6'b111010, 6'b111111: d.err = r.inst[12];
                6'b000000, 6'b000010, 6'b010011, 6'b000111, 6'b010101: begin
                    d.xsrc = 2'b01;
                    d.ysrc = r.inst[12] ? 2'b10 : 2'b01;
                end
                6'b110000, 6'b110001, 6'b110010, 6'b110011, 6'b110111:
                    d.ysrc = r.inst[12] ? 2'b10 : 2'b01;
                default: d.err = 1'b1;
            endcase
            if (STRICT != 0 && r.inst[14:13] != 2'b11) d.err = 1'b1;
        end
        return d;
    endfunction

    raw_t              mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]  occ_q, occ_d;
    logic              out_vld_q, out_vld_d;
    dec_t              out_q, out_d;
    logic [ECNT_W-1:0] err_cnt_q, err_cnt_d;
    logic              mem_we;
    raw_t              in_raw;

    logic push, load, q_empty, pop, bypass;

    assign in_raw  = '{pc: in_pc, inst: in_inst};
    assign in_rdy  = !flush && (occ_q < DEPTH_OCC);
    assign push    = in_vld && in_rdy;
    assign load    = !out_vld_q || out_rdy;
    assign q_empty = (occ_q == '0);
    assign pop     = load && !q_empty;
    assign bypass  = load && q_empty && push;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        occ_d     = occ_q;
        out_vld_d = out_vld_q;
        out_d     = out_q;
        err_cnt_d = err_cnt_q;
        mem_we    = 1'b0;
        if (flush) begin
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            occ_d     = '0;
            out_vld_d = 1'b0;
        end else begin
            mem_we = push && !bypass;
            if (mem_we) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop) begin
                rd_ptr_d  = rd_ptr_q + 1'b1;
                out_d     = decode(mem_q[rd_ptr_q]);
                out_vld_d = 1'b1;
            end else if (bypass) begin
                out_d     = decode(in_raw);
                out_vld_d = 1'b1;
            end else if (load) begin
                out_vld_d = 1'b0;
            end
            case ({mem_we, pop})
                2'b10:   occ_d = occ_q + 1'b1;
                2'b01:   occ_d = occ_q - 1'b1;
                default: occ_d = occ_q;
            endcase
            if (out_vld_q && out_rdy && out_q.err && err_cnt_q != '1)
                err_cnt_d = err_cnt_q + 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignment so all flops update together.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            occ_q     <= '0;
            out_vld_q <= 1'b0;
            out_q     <= '0;
            err_cnt_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            occ_q     <= occ_d;
            out_vld_q <= out_vld_d;
            out_q     <= out_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    // NOTE: queue storage is not reset; occupancy and pointers guard every read.
    always_ff @(posedge clk) begin
        if (mem_we) mem_q[wr_ptr_q] <= in_raw;
    end

    assign out_vld   = out_vld_q;
    assign out_pc    = out_q.pc;
    assign out_alu   = out_q.alu;
    assign out_xsrc  = out_q.xsrc;
    assign out_ysrc  = out_q.ysrc;
    assign out_imm   = out_q.imm;
    assign out_dst   = out_q.dst;
    assign out_jcond = out_q.jcond;
    assign out_err   = out_q.err;
    assign occ       = occ_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_id_pipe.sv
// Scoreboard bench for id_pipe: decoded entries are predicted on input transfer
// and compared on output transfer; directed cases cover backpressure, flush and reset.
module tb_id_pipe;

    logic        clk = 1'b0;
    logic        rstn;
    logic        in_vld, flush, out_rdy;
    logic [15:0] in_inst;
    logic [14:0] in_pc;
    logic        in_rdy, out_vld, out_err;
    logic [14:0] out_pc, out_imm;
    logic [5:0]  out_alu;
    logic [1:0]  out_xsrc, out_ysrc, occ;
    logic [2:0]  out_dst, out_jcond;
    logic [7:0]  err_cnt;

    // second instance: same stimulus, 2-bit error counter
    logic        in_rdy2, out_vld2, out_err2;
    logic [14:0] out_pc2, out_imm2;
    logic [5:0]  out_alu2;
    logic [1:0]  out_xsrc2, out_ysrc2, occ2;
    logic [2:0]  out_dst2, out_jcond2;
    logic [1:0]  err_cnt2;

    id_pipe dut (
        .clk(clk), .rstn(rstn), .in_vld(in_vld), .in_rdy(in_rdy), .in_inst(in_inst),
        .in_pc(in_pc), .flush(flush), .out_vld(out_vld), .out_rdy(out_rdy),
        .out_pc(out_pc), .out_alu(out_alu), .out_xsrc(out_xsrc), .out_ysrc(out_ysrc),
        .out_imm(out_imm), .out_dst(out_dst), .out_jcond(out_jcond), .out_err(out_err),
        .occ(occ), .err_cnt(err_cnt)
    );

    id_pipe #(.ECNT_W(2)) dut2 (
        .clk(clk), .rstn(rstn), .in_vld(in_vld), .in_rdy(in_rdy2), .in_inst(in_inst),
        .in_pc(in_pc), .flush(flush), .out_vld(out_vld2), .out_rdy(out_rdy),
        .out_pc(out_pc2), .out_alu(out_alu2), .out_xsrc(out_xsrc2), .out_ysrc(out_ysrc2),
        .out_imm(out_imm2), .out_dst(out_dst2), .out_jcond(out_jcond2), .out_err(out_err2),
        .occ(occ2), .err_cnt(err_cnt2)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cycle   = 0;
    int err_model = 0;
    logic [63:0] exp_q[$];
    logic        held = 1'b0;
    logic [63:0] snap;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Independent reference decode, packed in output-port order.
    function automatic logic [63:0] model(input logic [15:0] inst, input logic [14:0] pc);
        logic [5:0] comp;
        logic       a, er;
        logic [1:0] xs, ys;
        if (inst[15] == 1'b0)
            return 64'({pc, 6'b001100, 2'b10, 2'b00, inst[14:0], 3'b100, 3'b000, 1'b0});
        comp = inst[11:6];
        a    = inst[12];
        xs   = 2'b00;
        ys   = 2'b00;
        er   = 1'b0;
        if (comp inside {6'b001100, 6'b001101, 6'b001110, 6'b001111, 6'b011111}) begin
            xs = 2'b01;
            er = a;
        end else if (comp inside {6'b101010, 6'b111010, 6'b111111}) begin
            er = a;
        end else if (comp inside {6'b000000, 6'b000010, 6'b010011, 6'b000111, 6'b010101}) begin
            xs = 2'b01;
            ys = a ? 2'b10 : 2'b01;
        end else if (comp inside {6'b110000, 6'b110001, 6'b110010, 6'b110011, 6'b110111}) begin
            ys = a ? 2'b10 : 2'b01;
        end else begin
            er = 1'b1;
        end
        if (inst[14:13] != 2'b11) er = 1'b1;
        return 64'({pc, comp, xs, ys, 15'd0, inst[5:3], inst[2:0], er});
    endfunction

    function automatic logic [63:0] obs();
        return 64'({out_pc, out_alu, out_xsrc, out_ysrc, out_imm, out_dst, out_jcond, out_err});
    endfunction

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    // Scoreboard monitor: sampled mid-cycle, so it sees the values the next edge will use.
    always @(negedge clk) begin
        logic [63:0] e;
        if (!rstn) begin
            exp_q.delete();
            err_model = 0;
            held      = 1'b0;
        end else begin
            check("err_cnt", 64'(err_cnt), 64'(sat(err_model, 255)));
            check("err_cnt_w2", 64'(err_cnt2), 64'(sat(err_model, 3)));
            if (held) check("hold", obs(), snap);
            held = out_vld && !out_rdy && !flush;
            snap = obs();
            if (flush) begin
                exp_q.delete();
            end else begin
                if (out_vld && out_rdy) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_out", 64'(1), 64'(0));
                    end else begin
                        e = exp_q.pop_front();
                        check("entry", obs(), e);
                        if (e[0]) err_model++;
                    end
                end
                if (in_vld && in_rdy) exp_q.push_back(model(in_inst, in_pc));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one entry and hold it until accepted; returns #1 after the accepting edge.
    task automatic send(input logic [15:0] inst, input logic [14:0] pc);
        logic acc;
        acc     = 1'b0;
        in_vld  = 1'b1;
        in_inst = inst;
        in_pc   = pc;
        for (int t = 0; t < 50 && !acc; t++) begin
            @(negedge clk);
            acc = in_rdy;
            @(posedge clk);
            #1;
        end
        if (!acc) check("send_timeout", 64'(0), 64'(1));
        in_vld = 1'b0;
    endtask

    logic [15:0] pats [8];
    int c0, e0;

    initial begin
        pats = '{16'h7FFF, 16'hEC10, 16'hF1C8, 16'hE7C0, 16'hEA87, 16'hFC20, 16'h1234, 16'hEF88};
        rstn = 1'b0; in_vld = 1'b0; flush = 1'b0; out_rdy = 1'b0;
        in_inst = '0; in_pc = '0;
        #12;
        check("rst_out_vld", 64'(out_vld), 64'(0));
        check("rst_occ", 64'(occ), 64'(0));
        check("rst_err_cnt", 64'(err_cnt), 64'(0));
        check("rst_out_data", obs(), 64'(0));
        rstn = 1'b1;
        step();
        check("rdy_after_rst", 64'(in_rdy), 64'(1));

        // A-instruction, 1-cycle latency through bypass
        out_rdy = 1'b1;
        send(16'h0015, 15'd1);
        check("a_lat_vld", 64'(out_vld), 64'(1));
        check("a_xsrc", 64'(out_xsrc), 64'(2'b10));
        check("a_imm", 64'(out_imm), 64'(15'h0015));
        check("a_alu", 64'(out_alu), 64'(6'b001100));
        check("a_dst", 64'(out_dst), 64'(3'b100));
        check("a_err", 64'(out_err), 64'(0));

        send(16'hF1C8, 15'd2);
        check("c_xsrc", 64'(out_xsrc), 64'(2'b01));
        check("c_ysrc", 64'(out_ysrc), 64'(2'b10));
        check("c_dst", 64'(out_dst), 64'(3'b001));
        check("c_err", 64'(out_err), 64'(0));
        send(16'hFE90, 15'd3);
        check("illegal_err", 64'(out_err), 64'(1));
        step();
        check("illegal_cnt", 64'(err_cnt), 64'(1));

        // back-to-back streaming
        c0 = cycle;
        for (int i = 0; i < 8; i++) send(pats[i], 15'(10 + i));
        check("throughput_cycles", 64'(cycle - c0), 64'(8));
        repeat (3) step();

        // backpressure: DEPTH+1 entries fill output register and queue
        out_rdy = 1'b0;
        for (int i = 0; i < 3; i++) send(pats[i], 15'(20 + i));
        check("full_occ", 64'(occ), 64'(2));
        check("full_in_rdy", 64'(in_rdy), 64'(0));
        repeat (3) step();
        check("stall_pc", 64'(out_pc), 64'(20));
        out_rdy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("drain_vld", 64'(out_vld), 64'(1));
        end
        @(negedge clk);
        check("drain_done", 64'(out_vld), 64'(0));
        step();

        // flush with entries queued and input offered
        out_rdy = 1'b0;
        send(16'hFE90, 15'd30);
        send(16'h0001, 15'd31);
        send(16'h0002, 15'd32);
        check("pre_flush_occ", 64'(occ), 64'(2));
        e0 = int'(err_cnt);
        flush = 1'b1; in_vld = 1'b1; in_inst = 16'h0003; in_pc = 15'd33;
        step();
        flush = 1'b0; in_vld = 1'b0;
        check("flush_vld", 64'(out_vld), 64'(0));
        check("flush_occ", 64'(occ), 64'(0));
        check("flush_err_cnt", 64'(err_cnt), 64'(e0));
        out_rdy = 1'b1;
        repeat (3) step();
        check("flush_no_out", 64'(out_vld), 64'(0));

        // strict check and 2-bit saturation
        send(16'h8C10, 15'd40);
        check("strict_err", 64'(out_err), 64'(1));
        for (int i = 0; i < 4; i++) send(16'hFE90, 15'(41 + i));
        repeat (2) step();
        check("sat_w2", 64'(err_cnt2), 64'(3));

        // reset mid-stream
        out_rdy = 1'b0;
        for (int i = 0; i < 3; i++) send(pats[i], 15'(50 + i));
        check("mid_occ", 64'(occ), 64'(2));
        @(posedge clk);
        #3 rstn = 1'b0;
        #1;
        check("mrst_vld", 64'(out_vld), 64'(0));
        check("mrst_occ", 64'(occ), 64'(0));
        check("mrst_err_cnt", 64'(err_cnt), 64'(0));
        check("mrst_err_cnt_w2", 64'(err_cnt2), 64'(0));
        #8 rstn = 1'b1;
        step();
        out_rdy = 1'b1;
        repeat (4) step();
        check("no_stale", 64'(out_vld), 64'(0));

        // random traffic
        for (int i = 0; i < 400; i++) begin
            in_vld  = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 3) == 0)
                in_inst = 16'($urandom);
            else
                in_inst = {3'b111, 1'($urandom), 6'($urandom), 3'($urandom), 3'($urandom)};
            in_pc   = 15'(i);
            out_rdy = ($urandom_range(0, 3) != 0);
            flush   = ($urandom_range(0, 31) == 0);
            step();
        end
        flush = 1'b0; in_vld = 1'b0; out_rdy = 1'b1;
        repeat (6) step();
        check("sb_empty", 64'(exp_q.size()), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/id_pipe.md
ID_PIPE -- requirements
Module: id_pipe

Parameters
REQ-001 SHALL have parameter PC_W, default 15, width of the program-counter field.
REQ-002 SHALL have parameter DEPTH, default 2, input queue entries (power of two, >=2).
REQ-003 SHALL have parameter ECNT_W, default 8, width of the saturating error counter.
REQ-004 SHALL have parameter STRICT, default 1; when 1, a C-instruction with inst[14:13]!=2'b11 is illegal.

Interface
REQ-005 SHALL have ports (name direction width meaning):
- clk  in  1  clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- in_vld  in  1  fetch entry valid.
- in_rdy  out  1  id_pipe accepts entry.
- in_inst  in  16  Hack instruction.
- in_pc  in  PC_W  instruction address.
- flush  in  1  synchronous pipeline invalidate.
- out_vld  out  1  decoded entry valid.
- out_rdy  in  1  downstream accepts entry.
- out_pc  out  PC_W  pc of decoded entry.
- out_alu  out  6  zx,nx,zy,ny,f,no ALU control.
- out_xsrc  out  2  00 zero, 01 D, 10 imm.
- out_ysrc  out  2  00 zero, 01 A, 10 M.
- out_imm  out  15  immediate.
- out_dst  out  3  A,D,M write enables.
- out_jcond  out  3  jump condition.
- out_err  out  1  illegal instruction.
- occ  out  $clog2(DEPTH+1)  queue occupancy.
- err_cnt  out  ECNT_W  illegal instructions delivered.

Function
REQ-006 SHALL transfer input when in_vld&&in_rdy and output when out_vld&&out_rdy; no other event moves data.
REQ-007 SHALL drive in_rdy = !flush && (occ<DEPTH); in_rdy SHALL NOT depend combinationally on in_vld.
REQ-008 SHALL hold out_* stable while out_vld&&!out_rdy.
REQ-009 SHALL load the output register when it is empty or being drained, from queue head, or directly from the input when the queue is empty (bypass).
REQ-010 SHALL present an entry accepted at edge N on out_vld after edge N (1-cycle latency) when queue and output register are empty.
REQ-011 SHALL sustain one transfer per cycle with out_rdy held 1, preserving order.
REQ-012 SHALL, for inst[15]=0: xsrc=10, ysrc=00, imm=inst[14:0], alu=001100, dst=100, jcond=000, err=0.
REQ-013 SHALL, for inst[15]=1: alu=inst[11:6], dst=inst[5:3], jcond=inst[2:0], imm=0; a=inst[12].
REQ-014 SHALL decode comp {001100,001101,001110,001111,011111}: xsrc=01, ysrc=00, err=a.
REQ-015 SHALL decode comp {101010,111010,111111}: xsrc=00, ysrc=00, err=a.
REQ-016 SHALL decode comp {000000,000010,010011,000111,010101}: xsrc=01, ysrc=a?10:01, err=0.
REQ-017 SHALL decode comp {110000,110001,110010,110011,110111}: xsrc=00, ysrc=a?10:01, err=0.
REQ-018 SHALL decode any other comp: xsrc=ysrc=00, err=1; STRICT violation SHALL also set err=1.
REQ-019 SHALL, on flush, at the next edge empty the queue, clear out_vld, ignore in_vld that cycle; flush overrides simultaneous in/out transfers.
REQ-020 SHALL increment err_cnt on each output transfer with out_err=1, saturating at all-ones; flush SHALL NOT change err_cnt.
REQ-021 SHALL update occ every cycle for simultaneous push/pop (occ unchanged), push at full impossible, pop at empty ignored.

Reset
REQ-022 SHALL, while rstn=0, asynchronously force out_vld=0, occ=0, err_cnt=0, all out_* data fields=0, queue pointers=0; in_rdy=1 after release if flush=0.

Verification
REQ-023 Reset mid-stream with 2 queued entries -> out_vld=0, occ=0, err_cnt=0 immediately, no stale entry after release.
REQ-024 Push 16'h0015, out_rdy=1 -> next cycle out_vld=1, xsrc=10, imm=15'h0015, alu=001100, dst=100, err=0.
REQ-025 Push 16'hF1C8 (a=1,comp=000111,dst=001,jmp=000) -> xsrc=01, ysrc=10, dst=001, err=0; 16'hFE90 (a=1,comp=111010) -> err=1, err_cnt+1 on transfer.
REQ-026 out_rdy=0, push DEPTH+1 entries -> in_rdy=0 at occ=DEPTH, out_* stable; release out_rdy -> all entries emerge in order, one per cycle.
REQ-027 flush with in_vld=1, out_vld=1, occ=2 -> next cycle out_vld=0, occ=0, flushed input not delivered, err_cnt unchanged.
REQ-028 STRICT=1, push 16'h8C10 -> err=1; ECNT_W=2, deliver 5 illegal -> err_cnt=3.
